// File: rtl/game_flow_ctrl.sv
// Game phase sequencer for the Flappy Bird datapath: title/countdown/play/dying/over
// phase control, motion-block gating, pipe-pass scoring and session high score.
module game_flow_ctrl #(
    parameter logic [9:0]  BIRD_X       = 10'd160,
    parameter logic [9:0]  PIPE_W       = 10'd40,
    parameter logic [9:0]  GROUND_Y     = 10'd440,
    parameter int unsigned READY_FRAMES = 60,
    parameter int unsigned DYING_MAX    = 120,
    parameter int unsigned OVER_FRAMES  = 90
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       start_key,
    input  logic       collision,
    input  logic [9:0] bird_y,
    input  logic [9:0] pipe_x,
    output logic [2:0] state,
    output logic       physics_en,
    output logic       pipe_en,
    output logic       score_inc,
    output logic [7:0] score,
    output logic [7:0] high_score,
    output logic       title_on,
    output logic       over_on
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READY = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_DYING = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    localparam logic [7:0] READY_LIM = 8'(READY_FRAMES);
    localparam logic [7:0] DYING_LIM = 8'(DYING_MAX);
    localparam logic [7:0] OVER_LIM  = 8'(OVER_FRAMES);

    logic [2:0] state_r;
    logic [2:0] state_nxt_s;
    logic       key_q_r;
    logic       key_rise_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_inc_s;
    logic       armed_r;
    logic       armed_nxt_s;
    logic [7:0] score_r;
    logic [7:0] score_nxt_s;
    logic [7:0] high_score_r;
    logic [7:0] high_nxt_s;
    logic       score_hit_s;
    logic       passed_s;
    logic       score_inc_r;
    logic       physics_en_r;
    logic       pipe_en_r;
    logic       title_on_r;
    logic       over_on_r;
    logic       physics_nxt_s;
    logic       pipe_nxt_s;
    logic       title_nxt_s;
    logic       over_nxt_s;

    assign key_rise_s = start_key & ~key_q_r;
    // Counter saturates so a long stay in OVER never wraps below the key threshold.
    assign cnt_inc_s  = (cnt_r == 8'hFF) ? cnt_r : cnt_r + 8'd1;
    assign passed_s   = (({1'b0, pipe_x} + {1'b0, PIPE_W}) < {1'b0, BIRD_X});

    // Next-state, scoring and high-score decision logic.
    always_comb begin
        state_nxt_s = state_r;
        armed_nxt_s = armed_r;
        score_nxt_s = score_r;
        high_nxt_s  = high_score_r;
        score_hit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (key_rise_s) begin
                    state_nxt_s = ST_READY;
                    score_nxt_s = 8'd0;
                    armed_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READY: begin
                if (frame_tick && (cnt_inc_s == READY_LIM)) begin
                    state_nxt_s = ST_PLAY;
                end else begin
                    state_nxt_s = ST_READY;
                end
            end
            ST_PLAY: begin
                // Collision takes priority over a coincident scoring tick.
                if (collision) begin
                    state_nxt_s = ST_DYING;
                end else if (frame_tick) begin
                    if (!passed_s) begin
                        armed_nxt_s = 1'b1;
                    end else if (armed_r) begin
                        score_hit_s = 1'b1;
                        score_nxt_s = (score_r == 8'hFF) ? score_r : score_r + 8'd1;
                        armed_nxt_s = 1'b0;
                    end else begin
                        armed_nxt_s = armed_r;
                    end
                end else begin
                    state_nxt_s = ST_PLAY;
                end
            end
            ST_DYING: begin
                if (frame_tick && ((bird_y >= GROUND_Y) || (cnt_inc_s == DYING_LIM))) begin
                    state_nxt_s = ST_OVER;
                    high_nxt_s  = (score_r > high_score_r) ? score_r : high_score_r;
                end else begin
                    state_nxt_s = ST_DYING;
                end
            end
            ST_OVER: begin
                if (key_rise_s && (cnt_r >= OVER_LIM)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_OVER;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Moore output decode from the upcoming state so the flags register with it.
    always_comb begin
        physics_nxt_s = 1'b0;
        pipe_nxt_s    = 1'b0;
        title_nxt_s   = 1'b0;
        over_nxt_s    = 1'b0;
        case (state_nxt_s)
            ST_IDLE:  title_nxt_s = 1'b1;
            ST_READY: physics_nxt_s = 1'b0;
            ST_PLAY: begin
                physics_nxt_s = 1'b1;
                pipe_nxt_s    = 1'b1;
            end
            ST_DYING: physics_nxt_s = 1'b1;
            ST_OVER:  over_nxt_s = 1'b1;
            default:  title_nxt_s = 1'b0;
        endcase
    end

    // State, counter, scoring and registered output flags.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r      <= ST_IDLE;
            key_q_r      <= 1'b0;
            cnt_r        <= 8'd0;
            armed_r      <= 1'b0;
            score_r      <= 8'd0;
            high_score_r <= 8'd0;
            score_inc_r  <= 1'b0;
            physics_en_r <= 1'b0;
            pipe_en_r    <= 1'b0;
            title_on_r   <= 1'b1;
            over_on_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            key_q_r      <= start_key;
            armed_r      <= armed_nxt_s;
            score_r      <= score_nxt_s;
            high_score_r <= high_nxt_s;
            score_inc_r  <= score_hit_s;
            physics_en_r <= physics_nxt_s;
            pipe_en_r    <= pipe_nxt_s;
            title_on_r   <= title_nxt_s;
            over_on_r    <= over_nxt_s;
            if (state_nxt_s != state_r) begin
                cnt_r <= 8'd0;
            end else if (frame_tick) begin
                cnt_r <= cnt_inc_s;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign state      = state_r;
    assign physics_en = physics_en_r;
    assign pipe_en    = pipe_en_r;
    assign score_inc  = score_inc_r;
    assign score      = score_r;
    assign high_score = high_score_r;
    assign title_on   = title_on_r;
    assign over_on    = over_on_r;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed scoreboard bench for game_flow_ctrl: phases, scoring, high score,
// key gating in OVER, saturation and asynchronous reset.
module tb_game_flow_ctrl;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start_key = 1'b0;
    logic       collision = 1'b0;
    logic [9:0] bird_y = 10'd100;
    logic [9:0] pipe_x = 10'd300;
    logic [2:0] state;
    logic       physics_en;
    logic       pipe_en;
    logic       score_inc;
    logic [7:0] score;
    logic [7:0] high_score;
    logic       title_on;
    logic       over_on;

    game_flow_ctrl dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .start_key(start_key),
        .collision(collision), .bird_y(bird_y), .pipe_x(pipe_x), .state(state),
        .physics_en(physics_en), .pipe_en(pipe_en), .score_inc(score_inc), .score(score),
        .high_score(high_score), .title_on(title_on), .over_on(over_on)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   armed_m = 0;
    int   score_m = 0;
    int   high_m = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL sb_empty observed=%0d expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic key();
        start_key = 1'b1;
        step();
        start_key = 1'b0;
        step();
    endtask

    task automatic expect_phase(input logic [2:0] st);
        push("state", 32'(st));
        push("physics_en", 32'((st == 3'd2) || (st == 3'd3)));
        push("pipe_en", 32'(st == 3'd2));
        push("title_on", 32'(st == 3'd0));
        push("over_on", 32'(st == 3'd4));
    endtask

    task automatic check_phase();
        pop_chk(32'(state));
        pop_chk(32'(physics_en));
        pop_chk(32'(pipe_en));
        pop_chk(32'(title_on));
        pop_chk(32'(over_on));
    endtask

    // One PLAY frame with the pipe at px; expectation comes from the pass rule.
    task automatic play_tick(input int px);
        int exp_inc;
        pipe_x = 10'(px);
        exp_inc = 0;
        if (!((px + 40) < 160)) begin
            armed_m = 1;
        end else if (armed_m == 1) begin
            exp_inc = 1;
            score_m = (score_m == 255) ? 255 : score_m + 1;
            armed_m = 0;
        end
        push("score_inc", 32'(exp_inc));
        push("score", 32'(score_m));
        frame();
        pop_chk(32'(score_inc));
        pop_chk(32'(score));
    endtask

    task automatic start_game();
        expect_phase(3'd1);
        key();
        check_phase();
        armed_m = 0;
        score_m = 0;
        push("score_clr", 32'd0);
        pop_chk(32'(score));
        repeat (59) frame();
        expect_phase(3'd1);
        check_phase();
        expect_phase(3'd2);
        frame();
        check_phase();
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        expect_phase(3'd0);
        push("rst_score", 32'd0);
        push("rst_high", 32'd0);
        push("rst_inc", 32'd0);
        check_phase();
        pop_chk(32'(score));
        pop_chk(32'(high_score));
        pop_chk(32'(score_inc));
        Reset_n = 1'b1;
        step();

        // Game 1: countdown, two pipe sweeps
        start_game();
        for (int px = 300; px >= 100; px -= 5) play_tick(px);
        push("inc_one_clk", 32'd0);
        step();
        pop_chk(32'(score_inc));
        for (int px = 600; px >= 100; px -= 5) play_tick(px);
        push("score_two", 32'd2);
        pop_chk(32'(score));

        // Collision on a scoring tick
        play_tick(200);
        pipe_x = 10'd100;
        collision = 1'b1;
        expect_phase(3'd3);
        push("coll_score", 32'(score_m));
        push("coll_inc", 32'd0);
        frame();
        collision = 1'b0;
        check_phase();
        pop_chk(32'(score));
        pop_chk(32'(score_inc));

        // DYING: airborne tick stays, ground tick ends the game
        bird_y = 10'd300;
        expect_phase(3'd3);
        frame();
        check_phase();
        bird_y = 10'd440;
        high_m = (score_m > high_m) ? score_m : high_m;
        expect_phase(3'd4);
        push("high_g1", 32'(high_m));
        frame();
        check_phase();
        pop_chk(32'(high_score));
        bird_y = 10'd100;

        // OVER: early key dropped, key after 90 frames accepted
        repeat (10) frame();
        expect_phase(3'd4);
        key();
        check_phase();
        repeat (80) frame();
        expect_phase(3'd0);
        key();
        check_phase();

        // Game 2: lower score, DYING timeout, high score kept
        start_game();
        play_tick(200);
        play_tick(100);
        collision = 1'b1;
        expect_phase(3'd3);
        step();
        collision = 1'b0;
        check_phase();
        repeat (119) frame();
        expect_phase(3'd3);
        check_phase();
        high_m = (score_m > high_m) ? score_m : high_m;
        expect_phase(3'd4);
        push("high_keep", 32'(high_m));
        frame();
        check_phase();
        pop_chk(32'(high_score));
        repeat (90) frame();
        expect_phase(3'd0);
        key();
        check_phase();

        // Game 3: saturate the score
        start_game();
        for (int i = 0; i < 256; i++) begin
            play_tick(200);
            play_tick(100);
        end
        push("score_sat", 32'd255);
        pop_chk(32'(score));

        // Asynchronous reset mid-PLAY, checked before any further edge
        #2;
        expect_phase(3'd0);
        push("arst_score", 32'd0);
        push("arst_high", 32'd0);
        push("arst_inc", 32'd0);
        Reset_n = 1'b0;
        #1;
        check_phase();
        pop_chk(32'(score));
        pop_chk(32'(high_score));
        pop_chk(32'(score_inc));
        Reset_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Top-level game sequencer for the Flappy Bird datapath. It walks the game through title, countdown, play, dying and game-over phases, and gates the bird-physics and pipe-scroll blocks. It detects pipe passes to produce score pulses, owns the 8-bit current score, and keeps the session high score. It sits between keyboard decode, collision detect, the bird/pipe motion blocks and the on-screen score/text overlay.

Parameters:
BIRD_X, 10'd160, fixed bird left-edge x coordinate (pixels)
PIPE_W, 10'd40, pipe width (pixels)
GROUND_Y, 10'd440, bird_y at or beyond which the bird is on the ground
READY_FRAMES, 60, countdown length in frames (1..255)
DYING_MAX, 120, maximum frames spent in DYING (1..255)
OVER_FRAMES, 90, frames in OVER before a key is accepted (1..255)

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-Clk pulse per video frame
start_key  in  1  level; high while the start/flap key is held
collision  in  1  level; bird overlaps a pipe or the ceiling
bird_y  in  10  bird top y coordinate
pipe_x  in  10  nearest pipe left-edge x coordinate
state  out  3  0 IDLE, 1 READY, 2 PLAY, 3 DYING, 4 OVER
physics_en  out  1  bird physics enable
pipe_en  out  1  pipe scroll enable
score_inc  out  1  one-Clk pulse per scored pipe
score  out  8  current score
high_score  out  8  best score since reset
title_on  out  1  title overlay enable
over_on  out  1  game-over overlay enable

Behaviour:
- Reset (Reset_n low, asynchronous): state IDLE, score 0, high_score 0, score_inc 0, frame counter 0, armed 0, key-edge register 0. Outputs derived from state follow that state.
- Key edge: key_q <= start_key every Clk. key_rise = start_key & ~key_q. key_rise is sampled on any Clk edge, not only on frame_tick.
- Frame counter: 8-bit. Cleared on every state entry. Increments on frame_tick.
- State outputs are Moore and registered-state derived:
  - IDLE: title_on=1, physics_en=0, pipe_en=0.
  - READY: all enables 0.
  - PLAY: physics_en=1, pipe_en=1.
  - DYING: physics_en=1, pipe_en=0.
  - OVER: over_on=1, physics_en=0, pipe_en=0.
- Transitions:
  - IDLE -> READY on key_rise. On this transition score<=0 and armed<=0.
  - READY -> PLAY on the frame_tick that makes the counter equal READY_FRAMES. key_rise is ignored in READY.
  - PLAY -> DYING on any Clk with collision=1.
  - DYING -> OVER on a frame_tick with bird_y>=GROUND_Y, or on the frame_tick that makes the counter equal DYING_MAX. On this transition high_score <= (score>high_score) ? score : high_score.
  - OVER -> IDLE on key_rise, but only once counter>=OVER_FRAMES. Earlier key_rise events are dropped, not queued.
  - Unused state codes 5..7 go to IDLE on the next Clk.
- Scoring (PLAY only, evaluated on frame_tick):
  - passed = ({1'b0,pipe_x}+PIPE_W) < {1'b0,BIRD_X}, computed at 11 bits so there is no wrap.
  - If !passed, armed<=1.
  - If armed & passed: score_inc=1 for exactly that Clk, score<=score+1 saturating at 255, armed<=0.
  - When pipe_x wraps to the right edge, passed falls, which re-arms the next pipe.
- Simultaneous events: collision on the same Clk as a scoring frame_tick means collision wins. The state goes to DYING, with no increment and no pulse.
- Outside PLAY: score_inc=0 and score is held.
- Reset mid-game: immediate return to IDLE; high_score is lost.

Test Plan:
- Reset, pulse start_key, run 60 frame_ticks -> state 0->1 on the key edge; 1->2 on the 60th tick; physics_en/pipe_en rise together.
- In PLAY, sweep pipe_x 300 down to 100 in steps of 5 per tick (BIRD_X=160, PIPE_W=40) -> exactly one score_inc, on the first tick with pipe_x<120; score=1. Wrap pipe_x to 600 and repeat -> score=2.
- Assert collision on the same Clk as a scoring frame_tick -> state=3, score unchanged, score_inc stays 0.
- In DYING, drive bird_y=440 on a tick -> state=4, high_score=score. A second game with a lower score leaves high_score unchanged.
- In OVER, key_rise at frame 10 -> ignored. key_rise after 90 frames -> state=0, title_on=1.
- Preload score to 255 via repeated passes -> stays 255. Drop Reset_n mid-PLAY asynchronously -> all outputs at reset values with no Clk edge needed.
